// File: rtl/dmem_arbiter_if.sv
// Bundle of requester (CPU/host) and memory-side signals around the data-memory arbiter.
// slave: arbiter view; master: requesters plus memory view.
interface dmem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_gnt;
  logic          c_stall;

  logic          h_req;
  logic          h_lock;
  logic          h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic          h_gnt;

  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_we;
  logic [DW-1:0] mem_dout;
  logic [7:0]    stall_cnt;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  h_req, h_lock, h_we, h_addr, h_wdata,
    input  mem_dout,
    output c_gnt, c_stall, h_gnt, rdata,
    output mem_addr, mem_din, mem_we, stall_cnt
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output h_req, h_lock, h_we, h_addr, h_wdata,
    output mem_dout,
    input  c_gnt, c_stall, h_gnt, rdata,
    input  mem_addr, mem_din, mem_we, stall_cnt
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU vs host/debug loader, round robin with a bounded host lock.
// Grants are combinational and zero-latency; a denied CPU sees c_stall.
//
// state    | meaning
// ST_IDLE  | round-robin arbitration between C and H using r_last_h
// ST_HLOCK | host owns the port while h_req & h_lock, until forced yield to a waiting CPU
module dmem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  dmem_arbiter_if.slave bus
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_HLOCK = 1'b1
  } state_t;

  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

  state_t     r_st;
  logic       r_last_h;
  logic [3:0] r_hold;
  logic [7:0] r_stall_cnt;

  logic       w_lock_active;
  logic       w_force_yield;
  logic       w_gnt_c;
  logic       w_gnt_h;
  logic       w_stall;
  logic [3:0] w_hold_inc;

  logic [AW-1:0] w_mem_addr;
  logic [DW-1:0] w_mem_din;
  logic          w_mem_we;

  // Grants are forced low during reset so nothing can commit after rst_n falls.
  always_comb begin
    w_gnt_c       = 1'b0;
    w_gnt_h       = 1'b0;
    w_lock_active = (r_st == ST_HLOCK) && bus.h_req && bus.h_lock;
    w_force_yield = w_lock_active && bus.c_req && (r_hold >= HOLD_LIMIT);
    if (i_rst_n) begin
      if (w_force_yield) begin
        w_gnt_c = 1'b1;
      end else if (w_lock_active) begin
        w_gnt_h = 1'b1;
      end else if (bus.c_req && bus.h_req) begin
        w_gnt_c = r_last_h;
        w_gnt_h = ~r_last_h;
      end else begin
        w_gnt_c = bus.c_req;
        w_gnt_h = bus.h_req;
      end
    end
  end

  always_comb begin
    w_mem_addr = '0;
    w_mem_din  = '0;
    w_mem_we   = 1'b0;
    if (w_gnt_c) begin
      w_mem_addr = bus.c_addr;
      w_mem_din  = bus.c_wdata;
      w_mem_we   = bus.c_we;
    end else if (w_gnt_h) begin
      w_mem_addr = bus.h_addr;
      w_mem_din  = bus.h_wdata;
      w_mem_we   = bus.h_we;
    end
  end

  assign w_stall    = bus.c_req & ~w_gnt_c;
  assign w_hold_inc = (r_hold == 4'hF) ? r_hold : r_hold + 4'd1;

  assign bus.c_gnt     = w_gnt_c;
  assign bus.h_gnt     = w_gnt_h;
  assign bus.c_stall   = w_stall;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_din   = w_mem_din;
  assign bus.mem_we    = w_mem_we;
  assign bus.rdata     = bus.mem_dout;
  assign bus.stall_cnt = r_stall_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_st        <= ST_IDLE;
      r_last_h    <= 1'b1;
      r_hold      <= 4'd0;
      r_stall_cnt <= 8'd0;
    end else begin
      if (w_stall && (r_stall_cnt != 8'hFF)) begin
        r_stall_cnt <= r_stall_cnt + 8'd1;
      end

      if (w_gnt_c) begin
        r_last_h <= 1'b0;
      end else if (w_gnt_h) begin
        r_last_h <= 1'b1;
      end

      // Lock continues while H keeps asking; otherwise re-arm only on a fresh locked H win.
      if (w_lock_active && !w_force_yield) begin
        r_st   <= ST_HLOCK;
        r_hold <= w_hold_inc;
      end else if (w_gnt_h && bus.h_lock) begin
        r_st   <= ST_HLOCK;
        r_hold <= 4'd1;
      end else begin
        r_st   <= ST_IDLE;
        r_hold <= 4'd0;
      end
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port (8-bit addr, 8-bit din/dout, write enable) between two requesters:
  - port C: the CPU datapath (ALU result, register operand address).
  - port H: a host/debug loader that preloads or inspects memory, e.g. the mem20..mem30 result window.
- Sits between the requesters and the memory.
- Drives a stall to the PC/register write-enable path whenever the CPU is denied.

Parameters:
- AW, 8, address width.
- DW, 8, data width.
- MAX_HOLD, 4, maximum consecutive host-locked grants while the CPU is waiting (range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- c_req  in  1  CPU requests memory access this cycle.
- c_we  in  1  CPU access is a write.
- c_addr  in  AW  CPU address.
- c_wdata  in  DW  CPU write data.
- c_gnt  out  1  CPU granted this cycle.
- c_stall  out  1  c_req & ~c_gnt; gates pcwe/regwe.
- h_req  in  1  host requests access.
- h_lock  in  1  host asks to keep ownership on following cycles (burst).
- h_we  in  1  host access is a write.
- h_addr  in  AW  host address.
- h_wdata  in  DW  host write data.
- h_gnt  out  1  host granted this cycle.
- rdata  out  DW  mem_dout, broadcast; valid for the granted port.
- mem_addr  out  AW  to memory addr.
- mem_din  out  DW  to memory din.
- mem_we  out  1  to memory we.
- mem_dout  in  DW  memory combinational read data.
- stall_cnt  out  8  saturating count of c_stall cycles.

Behaviour:
- Memory contract: read is combinational (dout follows addr same cycle); write commits on the rising clk edge where we=1.
- Grant is combinational from current requests plus registered state.
  - An access completes in the cycle it is granted: zero-cycle latency, no wait states.
  - A requester holds req/we/addr/wdata stable until it sees gnt=1.
- Registered state:
  - st ∈ {IDLE, HLOCK}
  - last (0=C, 1=H)
  - hold[3:0]
  - stall_cnt[7:0]
- Reset (async, rst_n=0): st=IDLE, last=H (CPU wins the first tie), hold=0, stall_cnt=0. While rst_n=0, c_gnt=h_gnt=0, mem_we=0, mem_addr=0, mem_din=0.
- IDLE arbitration:
  - Only c_req: grant C.
  - Only h_req: grant H.
  - Both: grant the port ≠ last (round robin).
  - Neither: no grant.
  - On any grant, last ← granted port.
- IDLE→HLOCK: at an edge where H is granted with h_lock=1; hold ← 1.
- HLOCK: H is granted whenever h_req=1, regardless of c_req, until an exit condition.
  - Each granted H cycle: hold ← min(hold+1, 15).
- HLOCK exits (checked combinationally in the current cycle):
  - h_req=0 or h_lock=0 → this cycle is arbitrated as IDLE (last=H, so C wins any tie); st ← IDLE.
  - hold ≥ MAX_HOLD and c_req=1 → forced yield: C granted this cycle; st ← IDLE, hold ← 0, last ← C. H may re-enter lock on a later win.
  - c_req=0 with hold at MAX_HOLD → H keeps the lock; hold saturates at 15.
- Datapath mux:
  - mem_addr/mem_din/mem_we come from the granted port; mem_we = granted port's we.
  - No grant → addr=0, din=0, we=0.
  - mem_we is never 1 for an ungranted port.
- rdata = mem_dout at all times.
- c_stall = c_req & ~c_gnt. stall_cnt increments on each edge with c_stall=1 and saturates at 255.
- Simultaneous write by both ports to the same address: only the granted port's write commits; the other retries.
- Reset mid-lock: the lock is dropped and no write commits after rst_n falls.

Test Plan:
1. Reset, then c_req=1, c_we=1, c_addr=0x14, c_wdata=0x5A for one cycle → c_gnt=1, mem_we=1, mem_addr=0x14. Next cycle read 0x14 → rdata=0x5A; c_stall never 1.
2. c_req=h_req=1 (both reads) held 4 cycles with no lock → grants alternate C,H,C,H; c_stall=1 in cycles 2 and 4; stall_cnt=2.
3. Host burst: h_req=h_lock=1, writes 0x15..0x1C, c_req=0 → h_gnt=1 for all 8 cycles, st stays HLOCK, mem20-window bytes updated.
4. Forced yield, MAX_HOLD=4: host locked, c_req raised during the host's 2nd granted cycle → H granted cycles 1-4, C granted cycle 5, H regains cycle 6 (round robin). stall_cnt increments by 3.
5. Tie-break after reset: c_req=h_req=1 in the first cycle → C granted first.
6. Assert rst_n=0 mid-burst while h_we=1 → mem_we=0 immediately, h_gnt=0, stall_cnt=0. The target byte is unchanged after release.
